// File: rtl/sb_rx_transaction_decoder.sv
// USB4 sideband receive decoder: deserializes sbrx symbols and decodes
// DLE-framed Link Transactions and Address Transactions.
module sb_rx_transaction_decoder #(
    parameter int MAX_AT_LEN = 64,
    parameter int LEN_W      = $clog2(MAX_AT_LEN + 1)
) (
    input  logic             sb_clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sbrx,
    output logic             lt_valid,
    output logic [7:0]       lt_lse,
    output logic             at_data_valid,
    output logic [7:0]       at_data,
    output logic             at_end,
    output logic [LEN_W-1:0] at_len,
    output logic             at_is_rsp,
    output logic             rx_err,
    output logic             busy
);

    localparam logic [7:0] DLE     = 8'hFE;
    localparam logic [7:0] STX_CMD = 8'h05;
    localparam logic [7:0] STX_RSP = 8'h04;
    localparam logic [7:0] ETX     = 8'h40;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_AT_LEN);

    typedef enum logic [1:0] {B_IDLE, B_DATA, B_STOP, B_WAIT_HI} bit_state_t;
    typedef enum logic [2:0] {F_IDLE, F_DLE, F_LT_CLSE, F_AT_DATA, F_AT_DLE} frm_state_t;

    bit_state_t       bit_state, bit_next;
    logic [2:0]       bit_cnt, bit_cnt_next;
    logic [7:0]       shreg, shreg_next;
    logic             byte_stb, stop_err;

    frm_state_t       frm_state, frm_next;
    logic [7:0]       lse_q, lse_next;
    logic [LEN_W-1:0] len_cnt, len_next;

    logic             lt_valid_n, at_data_valid_n, at_end_n, at_is_rsp_n, rx_err_n;
    logic [7:0]       lt_lse_n, at_data_n;
    logic [LEN_W-1:0] at_len_n;

    // Bit-level deserializer; the byte strobe fires while the stop bit is sampled
    always_comb begin
        bit_next     = bit_state;
        bit_cnt_next = bit_cnt;
        shreg_next   = shreg;
        byte_stb     = 1'b0;
        stop_err     = 1'b0;
        case (bit_state)
            B_IDLE: begin
                if (!sbrx) begin
                    bit_next     = B_DATA;
                    bit_cnt_next = 3'd0;
                end
            end
            B_DATA: begin
                shreg_next   = {sbrx, shreg[7:1]};
                bit_cnt_next = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) bit_next = B_STOP;
            end
            B_STOP: begin
                if (sbrx) begin
                    byte_stb = 1'b1;
                    bit_next = B_IDLE;
                end else begin
                    stop_err = 1'b1;
                    bit_next = B_WAIT_HI;
                end
            end
            B_WAIT_HI: begin
                if (sbrx) bit_next = B_IDLE;
            end
            default: bit_next = B_IDLE;
        endcase
    end

    always_comb begin
        frm_next        = frm_state;
        lse_next        = lse_q;
        len_next        = len_cnt;
        lt_valid_n      = 1'b0;
        lt_lse_n        = lt_lse;
        at_data_valid_n = 1'b0;
        at_data_n       = at_data;
        at_end_n        = 1'b0;
        at_len_n        = at_len;
        at_is_rsp_n     = at_is_rsp;
        rx_err_n        = 1'b0;
        if (stop_err) begin
            rx_err_n = 1'b1;
            frm_next = F_IDLE;
        end else if (byte_stb) begin
            case (frm_state)
                F_IDLE: begin
                    if (shreg == DLE) frm_next = F_DLE;
                end
                F_DLE: begin
                    if (shreg == STX_CMD || shreg == STX_RSP) begin
                        at_is_rsp_n = (shreg == STX_RSP);
                        len_next    = '0;
                        frm_next    = F_AT_DATA;
                    end else if (shreg[7]) begin
                        lse_next = shreg;
                        frm_next = F_LT_CLSE;
                    end else begin
                        rx_err_n = 1'b1;
                        frm_next = F_IDLE;
                    end
                end
                F_LT_CLSE: begin
                    if (shreg == ~lse_q) begin
                        lt_valid_n = 1'b1;
                        lt_lse_n   = lse_q;
                    end else begin
                        rx_err_n = 1'b1;
                    end
                    frm_next = F_IDLE;
                end
                F_AT_DATA: begin
                    if (shreg == DLE) begin
                        frm_next = F_AT_DLE;
                    end else if (len_cnt == MAX_LEN) begin
                        rx_err_n = 1'b1;
                        frm_next = F_IDLE;
                    end else begin
                        at_data_valid_n = 1'b1;
                        at_data_n       = shreg;
                        len_next        = len_cnt + LEN_W'(1);
                    end
                end
                F_AT_DLE: begin
                    // A stuffed DLE counts against the payload limit like any other byte
                    if (shreg == DLE) begin
                        if (len_cnt == MAX_LEN) begin
                            rx_err_n = 1'b1;
                            frm_next = F_IDLE;
                        end else begin
                            at_data_valid_n = 1'b1;
                            at_data_n       = DLE;
                            len_next        = len_cnt + LEN_W'(1);
                            frm_next        = F_AT_DATA;
                        end
                    end else if (shreg == ETX) begin
                        at_end_n = 1'b1;
                        at_len_n = len_cnt;
                        frm_next = F_IDLE;
                    end else begin
                        rx_err_n = 1'b1;
                        frm_next = F_IDLE;
                    end
                end
                default: frm_next = F_IDLE;
            endcase
        end
    end

    always_ff @(posedge sb_clk) begin
        if (rst || !enable) begin
            bit_state     <= B_IDLE;
            bit_cnt       <= 3'd0;
            shreg         <= 8'd0;
            frm_state     <= F_IDLE;
            lse_q         <= 8'd0;
            len_cnt       <= '0;
            lt_valid      <= 1'b0;
            lt_lse        <= 8'd0;
            at_data_valid <= 1'b0;
            at_data       <= 8'd0;
            at_end        <= 1'b0;
            at_len        <= '0;
            at_is_rsp     <= 1'b0;
            rx_err        <= 1'b0;
        end else begin
            bit_state     <= bit_next;
            bit_cnt       <= bit_cnt_next;
            shreg         <= shreg_next;
            frm_state     <= frm_next;
            lse_q         <= lse_next;
            len_cnt       <= len_next;
            lt_valid      <= lt_valid_n;
            lt_lse        <= lt_lse_n;
            at_data_valid <= at_data_valid_n;
            at_data       <= at_data_n;
            at_end        <= at_end_n;
            at_len        <= at_len_n;
            at_is_rsp     <= at_is_rsp_n;
            rx_err        <= rx_err_n;
        end
    end

    assign busy = enable && ((bit_state != B_IDLE) || (frm_state != F_IDLE));

endmodule

// File: tb/tb_sb_rx_transaction_decoder.sv
// Directed self-checking bench for sb_rx_transaction_decoder (MAX_AT_LEN=4).
module tb_sb_rx_transaction_decoder;

    logic       sb_clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       sbrx = 1'b1;
    logic       lt_valid;
    logic [7:0] lt_lse;
    logic       at_data_valid;
    logic [7:0] at_data;
    logic       at_end;
    logic [2:0] at_len;
    logic       at_is_rsp;
    logic       rx_err;
    logic       busy;

    sb_rx_transaction_decoder #(.MAX_AT_LEN(4)) dut (
        .sb_clk(sb_clk), .rst(rst), .enable(enable), .sbrx(sbrx),
        .lt_valid(lt_valid), .lt_lse(lt_lse),
        .at_data_valid(at_data_valid), .at_data(at_data),
        .at_end(at_end), .at_len(at_len), .at_is_rsp(at_is_rsp),
        .rx_err(rx_err), .busy(busy)
    );

    always #5 sb_clk = ~sb_clk;

    int testsRun = 0;
    int testsFailed = 0;

    int         ltCount, endCount, errCount, multiCount;
    logic [7:0] lastLse;
    logic [2:0] lastLen;
    logic       lastRsp, lastDataRsp;
    logic [7:0] rxData[$];
    logic [7:0] txQ[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearCounts();
        ltCount = 0; endCount = 0; errCount = 0; multiCount = 0;
        lastLse = 8'h00; lastLen = 3'd0; lastRsp = 1'b0; lastDataRsp = 1'b0;
        rxData.delete();
    endtask

    // Called at each falling edge, halfway between DUT updates
    task automatic sampleOutputs();
        if (lt_valid) begin ltCount++; lastLse = lt_lse; end
        if (at_data_valid) begin rxData.push_back(at_data); lastDataRsp = at_is_rsp; end
        if (at_end) begin endCount++; lastLen = at_len; lastRsp = at_is_rsp; end
        if (rx_err) errCount++;
        if ((int'(lt_valid) + int'(at_end) + int'(rx_err)) > 1) multiCount++;
    endtask

    task automatic tick(input logic bitVal);
        @(negedge sb_clk);
        sampleOutputs();
        sbrx = bitVal;
    endtask

    task automatic sendSymbol(input logic [7:0] b, input logic stopBit);
        tick(1'b0);
        for (int i = 0; i < 8; i++) tick(b[i]);
        tick(stopBit);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1);
    endtask

    task automatic applyStimulus();
        foreach (txQ[i]) sendSymbol(txQ[i], 1'b1);
        txQ.delete();
        idle(4);
    endtask

    initial begin
        clearCounts();
        idle(3);
        checkOutput("reset_outputs",
                    {lt_valid, lt_lse, at_data_valid, at_data, at_end, at_len, at_is_rsp, rx_err},
                    32'd0);
        checkOutput("reset_busy", busy, 0);
        @(negedge sb_clk);
        rst = 1'b0;
        idle(2);

        // Valid LT
        clearCounts();
        txQ = '{8'hFE, 8'h85, 8'h7A};
        applyStimulus();
        checkOutput("lt_count", ltCount, 1);
        checkOutput("lt_lse", lastLse, 8'h85);
        checkOutput("lt_err", errCount, 0);
        checkOutput("lt_lse_held", lt_lse, 8'h85);

        // AT command with a stuffed DLE
        clearCounts();
        txQ = '{8'hFE, 8'h05, 8'h11, 8'h22, 8'hFE, 8'hFE, 8'h33, 8'hFE, 8'h40};
        applyStimulus();
        checkOutput("at_ndata", rxData.size(), 4);
        if (rxData.size() == 4) begin
            checkOutput("at_d0", rxData[0], 8'h11);
            checkOutput("at_d1", rxData[1], 8'h22);
            checkOutput("at_d2", rxData[2], 8'hFE);
            checkOutput("at_d3", rxData[3], 8'h33);
        end
        checkOutput("at_end", endCount, 1);
        checkOutput("at_len", lastLen, 3'd4);
        checkOutput("at_rsp", lastRsp, 0);
        checkOutput("at_err", errCount, 0);

        // Bad CLSE then good LT
        clearCounts();
        txQ = '{8'hFE, 8'h85, 8'h7B};
        applyStimulus();
        checkOutput("bclse_err", errCount, 1);
        checkOutput("bclse_lt", ltCount, 0);
        clearCounts();
        txQ = '{8'hFE, 8'h90, 8'h6F};
        applyStimulus();
        checkOutput("lt2_count", ltCount, 1);
        checkOutput("lt2_lse", lastLse, 8'h90);

        // Stop-bit error mid-AT, line held low, then immediate new AT
        clearCounts();
        sendSymbol(8'hFE, 1'b1);
        sendSymbol(8'h05, 1'b1);
        sendSymbol(8'h11, 1'b1);
        sendSymbol(8'h22, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0);
        idle(1);
        checkOutput("ferr_err", errCount, 1);
        checkOutput("ferr_ndata", rxData.size(), 1);
        clearCounts();
        txQ = '{8'hFE, 8'h05, 8'h33, 8'hFE, 8'h40};
        applyStimulus();
        checkOutput("ferr_next_ndata", rxData.size(), 1);
        if (rxData.size() == 1) checkOutput("ferr_next_d0", rxData[0], 8'h33);
        checkOutput("ferr_next_end", endCount, 1);
        checkOutput("ferr_next_len", lastLen, 3'd1);
        checkOutput("ferr_next_err", errCount, 0);

        // Payload overflow on the 5th byte of a response AT
        clearCounts();
        txQ = '{8'hFE, 8'h04, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        applyStimulus();
        checkOutput("ovf_ndata", rxData.size(), 4);
        if (rxData.size() == 4) checkOutput("ovf_d3", rxData[3], 8'hA4);
        checkOutput("ovf_err", errCount, 1);
        checkOutput("ovf_end", endCount, 0);
        checkOutput("ovf_rsp", lastDataRsp, 1);
        checkOutput("ovf_idle", busy, 0);

        // Reset during an AT payload
        clearCounts();
        txQ = '{8'hFE, 8'h05, 8'hB1, 8'hB2};
        foreach (txQ[i]) sendSymbol(txQ[i], 1'b1);
        txQ.delete();
        idle(1);
        checkOutput("rmid_ndata", rxData.size(), 2);
        checkOutput("rmid_busy_before", busy, 1);
        @(negedge sb_clk);
        rst = 1'b1;
        @(negedge sb_clk);
        checkOutput("rmid_outputs",
                    {lt_valid, lt_lse, at_data_valid, at_data, at_end, at_len, at_is_rsp, rx_err},
                    32'd0);
        checkOutput("rmid_busy", busy, 0);
        rst = 1'b0;
        idle(2);
        clearCounts();
        txQ = '{8'hFE, 8'h05, 8'hFE, 8'h40};
        applyStimulus();
        checkOutput("rmid_end", endCount, 1);
        checkOutput("rmid_len", lastLen, 3'd0);
        checkOutput("rmid_ndata2", rxData.size(), 0);

        // Disabled decoder ignores a valid LT
        clearCounts();
        enable = 1'b0;
        txQ = '{8'hFE, 8'hA0, 8'h5F};
        applyStimulus();
        checkOutput("dis_lt", ltCount, 0);
        checkOutput("dis_busy", busy, 0);
        enable = 1'b1;
        idle(2);
        clearCounts();
        txQ = '{8'hFE, 8'hA0, 8'h5F};
        applyStimulus();
        checkOutput("en_lt", ltCount, 1);
        checkOutput("en_lse", lastLse, 8'hA0);
        checkOutput("exclusive", multiCount, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/sb_rx_transaction_decoder.md
Name: sb_rx_transaction_decoder

Overview:
- Receive end of the USB4 sideband channel. Deserializes the bit-serial sbrx line and decodes Link Transactions (LT) and Address Transactions (AT) using DLE/STX/ETX framing.
- Sits between the electrical-layer sbrx pin and the lane-initialisation / config logic of the logical layer.
- It is the counterpart of the sideband transmit path that drives sbtx.

Parameters:
- MAX_AT_LEN, 64, maximum de-stuffed AT payload bytes accepted between STX and ETX.
- LEN_W, $clog2(MAX_AT_LEN+1), width of at_len.

Ports:
- sb_clk  input  1  sideband clock; one sbrx bit is sampled per rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  decoder enable; low forces the idle state with all pulses 0.
- sbrx  input  1  serial sideband receive line; idle level is 1.
- lt_valid  output  1  1-cycle pulse: valid LT received.
- lt_lse  output  8  LSE byte of the last valid LT; held until the next LT.
- at_data_valid  output  1  1-cycle pulse per de-stuffed AT payload byte.
- at_data  output  8  payload byte; valid with at_data_valid.
- at_end  output  1  1-cycle pulse: AT closed by DLE ETX.
- at_len  output  LEN_W  payload byte count; valid with at_end.
- at_is_rsp  output  1  1 if the current AT opened with STX_RSP; held from STX through at_end.
- rx_err  output  1  1-cycle pulse on any framing, protocol or overflow error.
- busy  output  1  high from a start bit until the framer returns to F_IDLE.

Behaviour:
- Reset or enable=0: every output is 0, both FSMs are in idle, and the counters are cleared. Reset asserted mid-symbol or mid-transaction discards all partial state in the same cycle.
- Symbol format: start bit 0, then 8 data bits LSB first, then stop bit 1. That is 10 sb_clk cycles per symbol.
- Constants: DLE=8'hFE, STX_CMD=8'h05, STX_RSP=8'h04, ETX=8'h40. An LSE is any byte with bit7=1.
- Bit FSM states: B_IDLE, B_DATA, B_STOP, B_WAIT_HI.
  - B_IDLE: sbrx=0 moves to B_DATA and clears the bit counter.
  - B_DATA: shifts 8 bits, then moves to B_STOP.
  - B_STOP with sbrx=1: the byte is delivered to the framer (byte strobe) and the FSM returns to B_IDLE. A start bit may be detected in the very next cycle, so back-to-back symbols are supported.
  - B_STOP with sbrx=0: rx_err pulses, the framer is forced to F_IDLE, and the FSM moves to B_WAIT_HI. B_WAIT_HI waits for sbrx=1 before returning to B_IDLE.
- Latency: every framer output pulse is asserted in the cycle after the stop bit is sampled.
- Framer FSM states: F_IDLE, F_DLE, F_LT_CLSE, F_AT_DATA, F_AT_DLE.
  - F_IDLE: on DLE go to F_DLE; any other byte is ignored with no error.
  - F_DLE:
    - STX_CMD or STX_RSP: set at_is_rsp, clear the length counter, go to F_AT_DATA.
    - LSE: store it, go to F_LT_CLSE.
    - Any other byte: rx_err, go to F_IDLE.
  - F_LT_CLSE:
    - byte == ~stored LSE: lt_valid pulses and lt_lse is updated.
    - Otherwise: rx_err.
    - Either way, go to F_IDLE.
  - F_AT_DATA: DLE goes to F_AT_DLE. Any other byte is emitted on at_data with at_data_valid, and the length counter increments.
  - F_AT_DLE:
    - DLE: emit data 8'hFE (stuffed DLE), go to F_AT_DATA.
    - ETX: pulse at_end with at_len equal to the count, go to F_IDLE.
    - Any other byte: rx_err, go to F_IDLE.
- Overflow: if a payload byte arrives when the count is already MAX_AT_LEN, that byte is not emitted. rx_err pulses and the framer goes to F_IDLE.
- Empty AT (DLE STX DLE ETX): at_end with at_len=0 and no at_data_valid pulses.
- at_end, lt_valid and rx_err are mutually exclusive in any cycle.

Test Plan:
- Reset, then LT: send FE, 85, 7A with sbrx otherwise 1 -> lt_valid pulses once, lt_lse=8'h85, rx_err=0.
- AT command: send FE 05 11 22 FE FE 33 FE 40 -> at_data_valid pulses with data 11, 22, FE, 33; at_end with at_len=4, at_is_rsp=0.
- Bad CLSE: send FE 85 7B -> rx_err pulses once and lt_valid=0. A following FE 90 6F then yields lt_valid with lt_lse=8'h90.
- Framing error: send a symbol whose stop bit is 0 in the middle of an AT, and hold sbrx=0 for 5 more cycles -> rx_err pulses once and no start bit is detected until sbrx=1. The next full AT decodes correctly.
- Overflow with MAX_AT_LEN=4: send FE 04 followed by 5 payload bytes -> exactly 4 at_data_valid pulses, then rx_err and no at_end.
- Reset mid-AT: assert rst for 1 cycle after 2 payload bytes -> all outputs 0 and busy=0. The next FE 05 FE 40 gives at_end with at_len=0.
